// File: rtl/ecc_encode_stream_if.sv
// Handshake bundle for ecc_encode_stream: payload in, SECDED codeword out.
// Signal names keep the original port names so existing hookups carry over.
interface ecc_encode_stream_if #(
   parameter int unsigned DataWidth = 64
);
   localparam int unsigned ParityWidth = $clog2(DataWidth + $clog2(DataWidth + 1) + 1);
   localparam int unsigned OutWidth    = DataWidth + ParityWidth + 1;

   logic                 valid_i;
   logic                 ready_o;
   logic [DataWidth-1:0] data_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [OutWidth-1:0]  data_o;

   modport master (
      output valid_i, data_i, ready_i,
      input  ready_o, valid_o, data_o
   );

   modport slave (
      input  valid_i, data_i, ready_i,
      output ready_o, valid_o, data_o
   );
endinterface

// File: rtl/ecc_encode_stream.sv
// Streaming extended-Hamming (SECDED) encoder with a 2-entry registered output
// buffer and a one-shot single/double bit fault injector.
module ecc_encode_stream #(
   parameter  int unsigned DataWidth     = 64,
   parameter  int unsigned ParityWidth   = $clog2(DataWidth + $clog2(DataWidth + 1) + 1),
   parameter  int unsigned CodeWordWidth = DataWidth + ParityWidth,
   parameter  int unsigned CntWidth      = 32,
   localparam int unsigned OutWidth      = CodeWordWidth + 1,
   localparam int unsigned PosWidth      = $clog2(OutWidth)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   ecc_encode_stream_if.slave  bus,
   input  logic                inj_single_i,
   input  logic                inj_double_i,
   input  logic [PosWidth-1:0] inj_pos_i,
   output logic                inj_pending_o,
   output logic [CntWidth-1:0] beat_cnt_o
);

   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOne   = 2'd1;
   localparam logic [1:0] StTwo   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                valid_q, valid_d;
   logic                ready_q, ready_d;
   logic [OutWidth-1:0] head_q, head_d;
   logic [OutWidth-1:0] tail_q, tail_d;
   logic                pend_q, pend_d;
   logic                dbl_q, dbl_d;
   logic [PosWidth-1:0] pos_q, pos_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic [CodeWordWidth-1:0] cw_enc;
   logic [OutWidth-1:0]      enc_word;
   logic [OutWidth-1:0]      inj_mask;
   logic [OutWidth-1:0]      wr_word;
   logic [PosWidth-1:0]      pos_next;
   logic [PosWidth-1:0]      pos_arm;
   logic                     accept;
   logic                     drain;
   logic                     arm;

   // Data bits fill non-power-of-two positions in order, then each parity bit
   // covers the positions whose index has its bit set.
   always_comb begin
      int unsigned k;
      logic        par;
      cw_enc = '0;
      k      = 0;
      for (int unsigned p = 1; p <= CodeWordWidth; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw_enc[p-1] = bus.data_i[k];
            k++;
         end
      end
      for (int unsigned i = 0; i < ParityWidth; i++) begin
         par = 1'b0;
         for (int unsigned p = 1; p <= CodeWordWidth; p++) begin
            if (((p >> i) & 1) != 0) par = par ^ cw_enc[p-1];
         end
         cw_enc[(1 << i) - 1] = par;
      end
      enc_word = {^cw_enc, cw_enc};
   end

   always_comb begin
      pos_next = (pos_q == PosWidth'(OutWidth - 1)) ? '0 : pos_q + 1'b1;
      inj_mask = (OutWidth'(1) << pos_q) | (dbl_q ? (OutWidth'(1) << pos_next) : '0);
      pos_arm  = (32'(inj_pos_i) >= OutWidth) ? inj_pos_i - PosWidth'(OutWidth) : inj_pos_i;
      accept   = bus.valid_i & ready_q;
      drain    = valid_q & bus.ready_i;
      arm      = inj_single_i | inj_double_i;
      wr_word  = enc_word ^ (pend_q ? inj_mask : '0);
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         StEmpty: begin
            if (accept) begin
               head_d  = wr_word;
               state_d = StOne;
            end
         end
         StOne: begin
            if (accept && drain) begin
               head_d = wr_word;
            end else if (accept) begin
               tail_d  = wr_word;
               state_d = StTwo;
            end else if (drain) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (drain) begin
               head_d  = tail_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
      valid_d = (state_d != StEmpty);
      ready_d = (state_d != StTwo);

      // A same-cycle arm wins over consumption: the current beat already used the old arm.
      pend_d = pend_q;
      dbl_d  = dbl_q;
      pos_d  = pos_q;
      if (arm) begin
         pend_d = 1'b1;
         dbl_d  = inj_double_i;
         pos_d  = pos_arm;
      end else if (accept) begin
         pend_d = 1'b0;
      end
      cnt_d = cnt_q + CntWidth'(drain);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StEmpty;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         pend_q  <= 1'b0;
         dbl_q   <= 1'b0;
         pos_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         pend_q  <= pend_d;
         dbl_q   <= dbl_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.valid_o   = valid_q;
   assign bus.ready_o   = ready_q;
   assign bus.data_o    = head_q;
   assign inj_pending_o = pend_q;
   assign beat_cnt_o    = cnt_q;

endmodule
